multicycle_control_unit: RTL and testbench

Multicycle RV32I controller that replaces single-cycle control decode with a state machine. It sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on a variable-latency memory via `mem_ready`. Compared with the single-cycle decoder it adds:
- a 4-bit ALU control covering the full RV32I ALU set;
- the full branch set, evaluated from ALU flags;
- JALR, LUI and AUIPC;
- an illegal-instruction trap.

It sits between the instruction register / ALU flags and the multicycle datapath muxes and enables.

---
 rtl/control_pkg.sv | 70 +++++++
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, datapath
// mux selects, ALU operations and base opcodes.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE_R,
        S_EXECUTE_I,
        S_ALU_WB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_UPPER,
        S_TRAP
    } state_t;

    typedef enum logic {
        CLASS_R,
        CLASS_I
    } alu_class_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction fields, ALU flags and memory handshake in; datapath controls out.
// The controller takes the master side, the datapath the slave side.
interface multicycle_control_unit_if;

    logic [6:0] opcode;
    logic [2:0] funct_3;
    logic [6:0] funct_7;
    logic       zero;
    logic       negative;
    logic       carry;
    logic       overflow;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;
    logic       illegal_instr;

    modport master (
        input  opcode, funct_3, funct_7, zero, negative, carry, overflow, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr
    );

    modport slave (
        output opcode, funct_3, funct_7, zero, negative, carry, overflow, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps an R-type or OP-IMM instruction to its ALU operation and flags
// funct_7 encodings that RV32I does not define.
module alu_decoder
    import control_pkg::*;
(
    input  alu_class_t op_class,
    input  logic [2:0] funct_3,
    input  logic [6:0] funct_7,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;

        case (funct_3)
            3'b000:  alu_ctrl = (op_class == CLASS_R && funct_7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLTU;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = funct_7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
        endcase

        // ADDI's upper bits are immediate, so only the shift forms constrain funct_7.
        if (op_class == CLASS_R) begin
            legal = (funct_7 == F7_BASE) ||
                    (funct_7 == F7_ALT && (funct_3 == 3'b000 || funct_3 == 3'b101));
        end else if (funct_3 == 3'b001) begin
            legal = (funct_7 == F7_BASE);
        end else if (funct_3 == 3'b101) begin
            legal = (funct_7 == F7_BASE) || (funct_7 == F7_ALT);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch through writeback, stalls on
// mem_ready, and parks in TRAP on any instruction it does not support.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter bit BRANCH_FULL = 1'b1,
    parameter bit UPPER_EN    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multicycle_control_unit_if.master    bus
);

    state_t     state;
    state_t     decode_next;
    alu_class_t op_class;
    logic [3:0] dec_alu_ctrl;
    logic       dec_legal;
    logic       taken;
    logic       branch_legal;
    logic [2:0] decode_imm;

    logic       pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s, illegal_s;

    assign op_class = (bus.opcode == OP_R) ? CLASS_R : CLASS_I;

    alu_decoder u_alu_decoder (
        .op_class (op_class),
        .funct_3  (bus.funct_3),
        .funct_7  (bus.funct_7),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    always_comb begin
        taken        = 1'b0;
        branch_legal = 1'b1;
        case (bus.funct_3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.negative ^ bus.overflow;
            3'b101:  taken = !(bus.negative ^ bus.overflow);
            3'b110:  taken = !bus.carry;
            3'b111:  taken = bus.carry;
            default: branch_legal = 1'b0;
        endcase
        if (!BRANCH_FULL && bus.funct_3[2]) branch_legal = 1'b0;
    end

    always_comb begin
        decode_next = S_TRAP;
        decode_imm  = IMM_I;
        case (bus.opcode)
            OP_LOAD:   decode_next = S_MEM_ADR;
            OP_STORE:  begin decode_next = S_MEM_ADR; decode_imm = IMM_S; end
            OP_R:      decode_next = dec_legal ? S_EXECUTE_R : S_TRAP;
            OP_IMM:    decode_next = dec_legal ? S_EXECUTE_I : S_TRAP;
            OP_BRANCH: begin decode_next = branch_legal ? S_BRANCH : S_TRAP; decode_imm = IMM_B; end
            OP_JAL:    begin decode_next = S_JAL; decode_imm = IMM_J; end
            OP_JALR:   decode_next = S_JALR;
            OP_LUI, OP_AUIPC: begin
                decode_next = UPPER_EN ? S_UPPER : S_TRAP;
                decode_imm  = IMM_U;
            end
            default:   decode_next = S_TRAP;
        endcase
    end

    // NOTE: state is sequential, so it is updated only with non-blocking
    // assignments; that keeps every reader seeing the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:     if (bus.mem_ready) state <= S_DECODE;
                S_DECODE:    state <= decode_next;
                S_MEM_ADR:   state <= (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WRITE: if (bus.mem_ready) state <= S_FETCH;
                S_MEM_WB, S_ALU_WB, S_BRANCH: state <= S_FETCH;
                S_EXECUTE_R, S_EXECUTE_I, S_JAL, S_UPPER: state <= S_ALU_WB;
                S_JALR:      state <= S_JAL;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        pc_write_s     = 1'b0;
        ir_write_s     = 1'b0;
        reg_write_s    = 1'b0;
        mem_read_s     = 1'b0;
        mem_write_s    = 1'b0;
        illegal_s      = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = RES_ALU_OUT;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_RS2;
        bus.alu_ctrl   = ALU_ADD;
        bus.imm_src    = IMM_I;

        case (state)
            S_FETCH: begin
                mem_read_s     = 1'b1;
                ir_write_s     = bus.mem_ready;
                pc_write_s     = bus.mem_ready;
                bus.alu_src_b  = SRC_B_FOUR;
                bus.result_src = RES_ALU;
            end
            S_DECODE: begin
                bus.alu_src_a = SRC_A_OLD_PC;
                bus.alu_src_b = SRC_B_IMM;
                bus.imm_src   = decode_imm;
            end
            S_MEM_ADR, S_JALR: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                bus.adr_src = 1'b1;
                mem_read_s  = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s    = 1'b1;
                bus.result_src = RES_MEM;
            end
            S_MEM_WRITE: begin
                bus.adr_src = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE_R: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_ctrl  = dec_alu_ctrl;
            end
            S_EXECUTE_I: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
                bus.alu_ctrl  = dec_alu_ctrl;
            end
            S_ALU_WB:    reg_write_s = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_ctrl  = ALU_SUB;
                pc_write_s    = taken;
            end
            S_JAL: begin
                pc_write_s    = 1'b1;
                bus.alu_src_a = SRC_A_OLD_PC;
                bus.alu_src_b = SRC_B_FOUR;
            end
            S_UPPER: begin
                bus.alu_src_a = (bus.opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
                bus.alu_src_b = SRC_B_IMM;
            end
            S_TRAP:      illegal_s = 1'b1;
            default:     illegal_s = 1'b1;
        endcase
    end

    // Enables are masked by rst_n itself so an abort kills them in the same cycle.
    assign bus.pc_write      = rst_n & pc_write_s;
    assign bus.ir_write      = rst_n & ir_write_s;
    assign bus.reg_write     = rst_n & reg_write_s;
    assign bus.mem_read      = rst_n & mem_read_s;
    assign bus.mem_write     = rst_n & mem_write_s;
    assign bus.illegal_instr = rst_n & illegal_s;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: stimulus pushes expected control words per cycle into a
// scoreboard; a negedge monitor pops and compares against both configurations.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [2:0] imm_src;
        logic       illegal;
    } ctl_t;

    typedef struct {
        int   dut;
        ctl_t exp;
    } sb_t;

    logic  clk = 1'b0;
    logic  rst_n;
    sb_t   sb_q[$];
    int    checks = 0;
    int    errors = 0;
    string test_name = "init";

    always #5 clk = ~clk;

    multicycle_control_unit_if bus0 ();
    multicycle_control_unit_if bus1 ();

    assign bus1.opcode    = bus0.opcode;
    assign bus1.funct_3   = bus0.funct_3;
    assign bus1.funct_7   = bus0.funct_7;
    assign bus1.zero      = bus0.zero;
    assign bus1.negative  = bus0.negative;
    assign bus1.carry     = bus0.carry;
    assign bus1.overflow  = bus0.overflow;
    assign bus1.mem_ready = bus0.mem_ready;

    multicycle_control_unit u_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    multicycle_control_unit #(
        .BRANCH_FULL (1'b0),
        .UPPER_EN    (1'b0)
    ) u_lite (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    function automatic ctl_t mk(input logic pw, iw, rw, mr, mw, as,
                                input logic [1:0] rs, a, b,
                                input logic [3:0] ac, input logic [2:0] imm,
                                input logic ill);
        ctl_t c;
        c.pc_write = pw; c.ir_write = iw; c.reg_write = rw;
        c.mem_read = mr; c.mem_write = mw; c.adr_src = as;
        c.result_src = rs; c.alu_src_a = a; c.alu_src_b = b;
        c.alu_ctrl = ac; c.imm_src = imm; c.illegal = ill;
        return c;
    endfunction

    function automatic ctl_t e_reset();            return mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_fetch(input logic r); return mk(r,r,0,1,0,0, 2'b10, 2'b00, 2'b10, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_decode(input logic [2:0] imm); return mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 4'b0000, imm, 0); endfunction
    function automatic ctl_t e_mem_adr();          return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_mem_read();         return mk(0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_mem_wb();           return mk(0,0,1,0,0,0, 2'b01, 2'b00, 2'b00, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_mem_write();        return mk(0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_exec_r(input logic [3:0] ac); return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, ac, 3'b000, 0); endfunction
    function automatic ctl_t e_exec_i(input logic [3:0] ac); return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, ac, 3'b000, 0); endfunction
    function automatic ctl_t e_alu_wb();           return mk(0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_branch(input logic t); return mk(t,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b000, 0); endfunction
    function automatic ctl_t e_jalr();             return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_jal();              return mk(1,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_upper(input logic [1:0] a); return mk(0,0,0,0,0,0, 2'b00, a, 2'b01, 4'b0000, 3'b000, 0); endfunction
    function automatic ctl_t e_trap();             return mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 1); endfunction

    function automatic ctl_t observe(input int d);
        ctl_t c;
        if (d == 0) begin
            c = mk(bus0.pc_write, bus0.ir_write, bus0.reg_write, bus0.mem_read,
                   bus0.mem_write, bus0.adr_src, bus0.result_src, bus0.alu_src_a,
                   bus0.alu_src_b, bus0.alu_ctrl, bus0.imm_src, bus0.illegal_instr);
        end else begin
            c = mk(bus1.pc_write, bus1.ir_write, bus1.reg_write, bus1.mem_read,
                   bus1.mem_write, bus1.adr_src, bus1.result_src, bus1.alu_src_a,
                   bus1.alu_src_b, bus1.alu_ctrl, bus1.imm_src, bus1.illegal_instr);
        end
        return c;
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        sb_t  e;
        ctl_t act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = observe(e.dut);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s dut%0d: got %b expected %b", test_name, e.dut, act, e.exp);
            end
        end
    end

    task automatic step(input ctl_t e0);
        sb_t s;
        s.dut = 0; s.exp = e0;
        sb_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input ctl_t e0, input ctl_t e1);
        sb_t s;
        s.dut = 1; s.exp = e1;
        sb_q.push_back(s);
        step(e0);
    endtask

    task automatic set_instr(input logic [31:0] ins);
        bus0.opcode  = ins[6:0];
        bus0.funct_3 = ins[14:12];
        bus0.funct_7 = ins[31:25];
    endtask

    task automatic do_reset(input string name);
        test_name = name;
        rst_n = 1'b0;
        step2(e_reset(), e_reset());
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus0.zero      = 1'b0;
        bus0.negative  = 1'b0;
        bus0.carry     = 1'b0;
        bus0.overflow  = 1'b0;
        bus0.mem_ready = 1'b1;
        set_instr(32'h0000_0013);
        @(posedge clk);
        #1;

        test_name = "reset";
        step2(e_reset(), e_reset());
        step2(e_reset(), e_reset());
        rst_n = 1'b1;

        // add x1,x2,x3 with one fetch stall and mem_ready ignored in DECODE
        test_name = "add";
        set_instr(32'h0031_00B3);
        bus0.mem_ready = 1'b0; step(e_fetch(1'b0));
        bus0.mem_ready = 1'b1; step(e_fetch(1'b1));
        bus0.mem_ready = 1'b0; step(e_decode(3'b000));
        bus0.mem_ready = 1'b1; step(e_exec_r(4'b0000));
        step(e_alu_wb());

        test_name = "lw_stall";
        set_instr(32'h0001_2083);
        step(e_fetch(1'b1));
        step(e_decode(3'b000));
        step(e_mem_adr());
        bus0.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(e_mem_read());
        bus0.mem_ready = 1'b1;
        step(e_mem_read());
        step(e_mem_wb());

        do_reset("reset_sync");
        test_name = "bne_not_taken";
        set_instr(32'h0020_9463);
        bus0.zero = 1'b1;
        step2(e_fetch(1'b1), e_fetch(1'b1));
        step2(e_decode(3'b010), e_decode(3'b010));
        step2(e_branch(1'b0), e_branch(1'b0));
        bus0.zero = 1'b0;

        test_name = "blt_taken";
        set_instr(32'h0020_C463);
        bus0.negative = 1'b1; bus0.overflow = 1'b0;
        step2(e_fetch(1'b1), e_fetch(1'b1));
        step2(e_decode(3'b010), e_decode(3'b010));
        step2(e_branch(1'b1), e_trap());
        bus0.negative = 1'b0;

        do_reset("reset_after_blt");
        test_name = "bgeu_not_taken";
        set_instr(32'h0020_F463);
        bus0.carry = 1'b0;
        step(e_fetch(1'b1));
        step(e_decode(3'b010));
        step(e_branch(1'b0));

        test_name = "jalr";
        set_instr(32'h0001_00E7);
        step(e_fetch(1'b1));
        step(e_decode(3'b000));
        step(e_jalr());
        step(e_jal());
        step(e_alu_wb());

        test_name = "jal";
        set_instr(32'h0080_00EF);
        step(e_fetch(1'b1));
        step(e_decode(3'b011));
        step(e_jal());
        step(e_alu_wb());

        do_reset("reset_before_lui");
        test_name = "lui";
        set_instr(32'h1234_50B7);
        step2(e_fetch(1'b1), e_fetch(1'b1));
        step2(e_decode(3'b100), e_decode(3'b100));
        step2(e_upper(2'b11), e_trap());
        step2(e_alu_wb(), e_trap());

        test_name = "auipc";
        set_instr(32'h0000_0097);
        step(e_fetch(1'b1));
        step(e_decode(3'b100));
        step(e_upper(2'b01));
        step(e_alu_wb());

        test_name = "srai";
        set_instr(32'h4031_5093);
        step(e_fetch(1'b1));
        step(e_decode(3'b000));
        step(e_exec_i(4'b1001));
        step(e_alu_wb());

        test_name = "slli_bad_f7";
        set_instr(32'h4031_1093);
        step(e_fetch(1'b1));
        step(e_decode(3'b000));
        step(e_trap());

        do_reset("reset_after_slli");
        test_name = "sub_bad_f7";
        set_instr(32'h0231_00B3);
        step(e_fetch(1'b1));
        step(e_decode(3'b000));
        step(e_trap());
        step(e_trap());
        do_reset("reset_from_trap");

        test_name = "sw_abort";
        set_instr(32'h0011_2023);
        step(e_fetch(1'b1));
        step(e_decode(3'b001));
        step(e_mem_adr());
        bus0.mem_ready = 1'b0;
        step(e_mem_write());
        step(e_mem_write());
        rst_n = 1'b0;
        step(e_reset());
        rst_n = 1'b1;
        bus0.mem_ready = 1'b1;
        step(e_fetch(1'b1));
        step(e_decode(3'b001));

        @(negedge clk);
        #1;
        test_name = "drain";
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending entries expected 0", test_name, sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
